doce_rx_mac_filter: RTL and testbench
=====================================

# doce_rx_mac_filter

Receive-path MAC destination filter placed directly upstream of the transport-layer RX FSM: it accepts frames from the router, inspects the destination MAC on the first beat, and forwards matching frames through a one-beat registered stage. Non-matching and runt frames are consumed and discarded. The transport layer only sees frames addressed to this node. Saturating pass/drop counters are exposed for the control plane.

## Interface
- DATA_WIDTH, 16, beat width in bytes; must be ≥ 16.
- CNT_WIDTH, 32, width of the statistics counters.

- user_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_tdata  in  DATA_WIDTH*8  frame data from the router.
- s_tkeep  in  DATA_WIDTH  byte enables.
- s_tuser  in  4  per-beat sideband.
- s_tvalid  in  1  input beat valid.
- s_tlast  in  1  last beat of the frame.
- s_tready  out  1  ready to the router.
- m_tdata  out  DATA_WIDTH*8  data toward the RX FSM.
- m_tkeep  out  DATA_WIDTH  byte enables.
- m_tuser  out  4  sideband, copied from s_tuser of the same beat.
- m_tvalid  out  1  output beat valid.
- m_tlast  out  1  last beat of the frame.
- m_tready  in  1  ready from the RX FSM.
- local_mac  in  48  this node's MAC address.
- filter_en  in  1  1 = filter; 0 = forward every frame (runt check still applies).
- pass_cnt  out  CNT_WIDTH  frames forwarded, saturating.
- drop_cnt  out  CNT_WIDTH  frames discarded for MAC mismatch, saturating.
- runt_cnt  out  CNT_WIDTH  frames discarded as runts, saturating.

## Operation
- States: HEAD (awaiting a first beat), PASS (forwarding the body), DROP (discarding the body).
- **HEAD, on an accepted beat:**
  - Destination MAC is s_tdata[95:48].
  - runt = s_tlast & ~&s_tkeep[13:0].
  - match = ~filter_en | (dst == local_mac) | (bcast & dst == 48'hFFFF_FFFF_FFFF).
  - bcast is 1 only when the configuration macro is defined.
- **Priority of the HEAD decision:**
  - runt: discard the beat and increment runt_cnt.
  - else match: forward the beat. Go to PASS if !s_tlast; otherwise stay in HEAD. Increment pass_cnt when the first beat is accepted.
  - else: discard the beat and increment drop_cnt. Go to DROP if !s_tlast.
- **PASS:** forward each accepted beat; return to HEAD on the accepted s_tlast beat.
- **DROP:** consume each beat with s_tready = 1; return to HEAD on the s_tlast beat. Nothing is presented on m_*.
- local_mac and filter_en are sampled only on the HEAD beat. Changing them mid-frame does not affect that frame.
- Counters saturate at all-ones and never wrap.

## Timing
- **Output register:** a single register stage holds m_tdata, m_tkeep, m_tuser, m_tlast and m_tvalid.
- **Latency:** 1 cycle from an accepted s_* beat to its appearance on m_*.
- **Ready, HEAD/PASS:** s_tready = ~m_tvalid | m_tready. This sustains full throughput with no bubbles.
- **Ready, DROP:** s_tready = 1.
- **Ready, discarded HEAD beat:** accepted under the same rule as HEAD/PASS. The output register is not loaded.
- **Output hold:** m_* stays stable while m_tvalid & ~m_tready.
- **Register update on a cycle where the held beat drains and a new beat is accepted:** the register loads the new beat and m_tvalid stays 1.
- **Register update on a cycle where the held beat drains and no beat is accepted:** m_tvalid drops to 0.
- **Counters:** update in the cycle after the first beat is accepted.
- **Reset values:** state = HEAD; m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser = 0; s_tready = 1 in the first cycle after reset; all counters = 0.
- **Reset mid-frame:** the held output beat is lost. The next input beat is treated as a new HEAD beat and classified normally. The router must restart frames after a reset.

## Configuration
- DOCE_RX_BCAST_ACCEPT_EN defined: frames with destination ff:ff:ff:ff:ff:ff are forwarded and counted in pass_cnt.
- DOCE_RX_BCAST_ACCEPT_EN undefined: broadcast is treated as a mismatch when filter_en = 1, and counted in drop_cnt.

## Test plan
- **Match:** local_mac = 0x0A0B0C0D0E0F; 3-beat frame with dst 0x0A0B0C0D0E0F, m_tready = 1 → 3 beats on m_* one cycle later, tuser preserved; pass_cnt = 1.
- **Mismatch:** 4-beat frame with dst 0x112233445566, filter_en = 1 → m_tvalid stays 0; s_tready = 1 on all 4 beats; drop_cnt = 1; a following matching frame forwards normally.
- **Backpressure:** matching 5-beat frame with m_tready toggling 1,0,0,1,… → no beat lost or duplicated, m_* stable while stalled; s_tready = 0 whenever m_tvalid & ~m_tready.
- **Runt and back-to-back:**
  - single beat with tlast and s_tkeep = 16'h0FFF → discarded, runt_cnt = 1;
  - a back-to-back single-beat matching frame in the next cycle → forwarded.
- **Broadcast:** dst all-ones, filter_en = 1 → forwarded with the macro defined; dropped (drop_cnt + 1) without it. With filter_en = 0 and dst 0x112233445566 → forwarded.
- **Reset mid-frame:** assert reset during beat 2 of a 4-beat PASS frame → next cycle m_tvalid = 0, all counters = 0, state HEAD; resumed beat 3 (dst bits not matching) → dropped.

Source files
------------

// File: rtl/doce_rx_mac_filter.sv
// rtl/doce_rx_mac_filter.sv - RX destination-MAC filter with one-beat output register and saturating stats.
// Optional feature: define DOCE_RX_BCAST_ACCEPT_EN to accept ff:ff:ff:ff:ff:ff when filtering.
module doce_rx_mac_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH*8-1:0] s_tdata,
  input  logic [DATA_WIDTH-1:0]   s_tkeep,
  input  logic [3:0]              s_tuser,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_WIDTH*8-1:0] m_tdata,
  output logic [DATA_WIDTH-1:0]   m_tkeep,
  output logic [3:0]              m_tuser,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  input  logic [47:0]             local_mac,
  input  logic                    filter_en,
  output logic [CNT_WIDTH-1:0]    pass_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic [CNT_WIDTH-1:0]    runt_cnt
);

`ifdef DOCE_RX_BCAST_ACCEPT_EN
  localparam logic BCAST_EN = 1'b1;
`else
  localparam logic BCAST_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {HEAD, PASS, DROP} state_t;

  state_t      state, state_nxt;
  logic [47:0] dst;
  logic        runt, match, accept, load;
  logic        inc_pass, inc_drop, inc_runt;

  always_comb begin
    dst       = s_tdata[95:48];
    runt      = s_tlast & ~&s_tkeep[13:0];
    match     = ~filter_en | (dst == local_mac) | (BCAST_EN & (dst == 48'hFFFF_FFFF_FFFF));
    // DROP never loads the output register, so it can always sink the router.
    s_tready  = (state == DROP) ? 1'b1 : (~m_tvalid | m_tready);
    accept    = s_tvalid & s_tready;
    state_nxt = state;
    load      = 1'b0;
    inc_pass  = 1'b0;
    inc_drop  = 1'b0;
    inc_runt  = 1'b0;
    case (state)
      HEAD: begin
        if (accept) begin
          if (runt) begin
            inc_runt = 1'b1;
          end else if (match) begin
            load     = 1'b1;
            inc_pass = 1'b1;
            if (!s_tlast) state_nxt = PASS;
          end else begin
            inc_drop = 1'b1;
            if (!s_tlast) state_nxt = DROP;
          end
        end
      end
      PASS: begin
        if (accept) begin
          load = 1'b1;
          if (s_tlast) state_nxt = HEAD;
        end
      end
      DROP: begin
        if (accept && s_tlast) state_nxt = HEAD;
      end
      default: state_nxt = HEAD;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state    <= HEAD;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= '0;
      pass_cnt <= '0;
      drop_cnt <= '0;
      runt_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= s_tdata;
        m_tkeep  <= s_tkeep;
        m_tuser  <= s_tuser;
        m_tlast  <= s_tlast;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (inc_pass && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_ONE;
      if (inc_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_ONE;
      if (inc_runt && (runt_cnt != '1)) runt_cnt <= runt_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_doce_rx_mac_filter.sv
// tb/tb_doce_rx_mac_filter.sv - Directed self-checking bench for doce_rx_mac_filter.
module tb_doce_rx_mac_filter;
  localparam int DW = 16;
  localparam int CW = 3;
  localparam logic [47:0] LM = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] OTHER = 48'h1122_3344_5566;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

  logic           user_clk = 1'b0;
  logic           reset;
  logic [127:0]   s_tdata;
  logic [15:0]    s_tkeep;
  logic [3:0]     s_tuser;
  logic           s_tvalid, s_tlast, s_tready;
  logic [127:0]   m_tdata;
  logic [15:0]    m_tkeep;
  logic [3:0]     m_tuser;
  logic           m_tvalid, m_tlast, m_tready;
  logic [47:0]    local_mac;
  logic           filter_en;
  logic [CW-1:0]  pass_cnt, drop_cnt, runt_cnt;

  doce_rx_mac_filter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .user_clk(user_clk), .reset(reset),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .local_mac(local_mac), .filter_en(filter_en),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic [3:0]   u;
    logic         l;
  } beat_t;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] keep;
    logic        fen;
    int          cls;
  } vec_t;

  beat_t   q[$];
  int      tests = 0;
  int      fails = 0;
  int      exp_pass = 0, exp_drop = 0, exp_runt = 0;
  int      seq = 0;
  bit      bp_en = 0;
  bit      chk_ready = 0;
  int      bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;
  bit      stall_prev = 0;
  beat_t   held;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? (1 << CW) - 1 : x + 1;
  endfunction

  function automatic logic [127:0] mkbeat(input logic [47:0] dst, input int s);
    logic [31:0] sv;
    sv = s;
    return {8'hA0, sv[23:0], dst, sv[15:0], 32'h1234_5678 ^ sv};
  endfunction

  task automatic chk_cnts(input string name);
    chk({name, "_pass"}, 128'(pass_cnt), 128'(exp_pass));
    chk({name, "_drop"}, 128'(drop_cnt), 128'(exp_drop));
    chk({name, "_runt"}, 128'(runt_cnt), 128'(exp_runt));
  endtask

  // Back-pressure pattern 1,0,0,1 applied just after each rising edge.
  always @(posedge user_clk) begin
    #1;
    if (bp_en) begin
      m_tready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end
  end

  // Output scoreboard: pops expected beats on every handshake and checks hold while stalled.
  always @(negedge user_clk) begin
    beat_t e;
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 128'(m_tvalid), 128'(1'b1));
        chk("hold_beat", 128'({m_tdata, m_tkeep, m_tuser, m_tlast}), 128'(held));
      end
      if (chk_ready && m_tvalid && !m_tready) chk("ready_low_on_stall", 128'(s_tready), 128'(1'b0));
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 128'(m_tdata), 128'(0));
        end else begin
          e = q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep_user_last", 128'({m_tkeep, m_tuser, m_tlast}), 128'({e.k, e.u, e.l}));
        end
      end
      stall_prev = m_tvalid & ~m_tready;
      held = {m_tdata, m_tkeep, m_tuser, m_tlast};
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic [3:0] u,
                           input logic l, input bit fwd, output int waits);
    bit acc;
    beat_t b;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    waits = 0;
    acc = 0;
    while (!acc && waits < 40) begin
      @(negedge user_clk);
      acc = s_tready;
      @(posedge user_clk);
      if (acc) begin
        if (fwd) begin
          b.d = d; b.k = k; b.u = u; b.l = l;
          q.push_back(b);
        end
      end else begin
        waits++;
      end
    end
    #1;
    s_tvalid = 1'b0;
    if (!acc) chk("accept_timeout", 128'(1'b0), 128'(1'b1));
  endtask

  // cls: 0 = forwarded, 1 = dropped (mismatch), 2 = runt.
  task automatic send_frame(input logic [47:0] dst, input int n, input logic [15:0] klast,
                            input int cls, input bit no_wait_chk);
    int w;
    logic [15:0] k;
    if (cls == 0) exp_pass = sat(exp_pass);
    else if (cls == 1) exp_drop = sat(exp_drop);
    else exp_runt = sat(exp_runt);
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1) ? klast : 16'hFFFF;
      seq++;
      send_beat(mkbeat(dst, seq), k, seq[3:0], (i == n - 1), (cls == 0), w);
      if (no_wait_chk) chk("drop_ready_high", 128'(w), 128'(0));
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge user_clk);
    #1;
    chk({name, "_all_out"}, 128'(q.size()), 128'(0));
    chk_cnts(name);
  endtask

  vec_t vecs[10];
  int   w;

  initial begin
    vecs[0] = '{LM,    16'hFFFF, 1'b1, 0};
    vecs[1] = '{OTHER, 16'hFFFF, 1'b1, 1};
    vecs[2] = '{LM,    16'h0FFF, 1'b1, 2};
    vecs[3] = '{LM,    16'h3FFF, 1'b1, 0};
    vecs[4] = '{OTHER, 16'h1FFF, 1'b1, 2};
`ifdef DOCE_RX_BCAST_ACCEPT_EN
    vecs[5] = '{BC,    16'hFFFF, 1'b1, 0};
`else
    vecs[5] = '{BC,    16'hFFFF, 1'b1, 1};
`endif
    vecs[6] = '{OTHER, 16'hFFFF, 1'b0, 0};
    vecs[7] = '{BC,    16'hFFFF, 1'b0, 0};
    vecs[8] = '{48'h0A0B_0C0D_0E0E, 16'hFFFF, 1'b1, 1};
    vecs[9] = '{OTHER, 16'h0000, 1'b0, 2};

    reset = 1'b1; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; local_mac = LM; filter_en = 1'b1;
    repeat (3) @(posedge user_clk);
    #1;
    reset = 1'b0;
    chk("rst_m_outputs", 128'({m_tvalid, m_tlast, m_tkeep, m_tuser}), 128'(0));
    chk("rst_m_tdata", m_tdata, 128'(0));
    chk("rst_s_tready", 128'(s_tready), 128'(1'b1));
    chk_cnts("rst");

    send_frame(LM, 3, 16'hFFFF, 0, 0);
    drain("match3");

    send_frame(OTHER, 4, 16'hFFFF, 1, 1);
    send_frame(LM, 2, 16'h00FF, 0, 0);
    drain("mismatch4");

    chk_ready = 1;
    bp_idx = 0;
    bp_en = 1;
    send_frame(LM, 5, 16'hFFFF, 0, 0);
    repeat (6) @(posedge user_clk);
    bp_en = 0;
    #2;
    m_tready = 1'b1;
    chk_ready = 0;
    drain("backpressure");

    send_frame(LM, 1, 16'h0FFF, 2, 0);
    send_frame(LM, 1, 16'hFFFF, 0, 0);
    drain("runt_b2b");

    for (int i = 0; i < 10; i++) begin
      filter_en = vecs[i].fen;
      send_frame(vecs[i].dst, 1, vecs[i].keep, vecs[i].cls, 0);
      drain($sformatf("vec%0d", i));
    end
    filter_en = 1'b1;
    chk("pass_saturated", 128'(pass_cnt), 128'((1 << CW) - 1));

    send_beat(mkbeat(LM, 900), 16'hFFFF, 4'h3, 1'b0, 1'b1, w);
    s_tdata = mkbeat(LM, 901); s_tkeep = 16'hFFFF; s_tuser = 4'h4; s_tlast = 1'b0; s_tvalid = 1'b1;
    reset = 1'b1;
    q.delete();
    @(posedge user_clk);
    #1;
    reset = 1'b0;
    s_tvalid = 1'b0;
    exp_pass = 0; exp_drop = 0; exp_runt = 0;
    chk("midrst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    chk_cnts("midrst");
    exp_drop = 1;
    seq++;
    send_beat(mkbeat(OTHER, 902), 16'hFFFF, 4'h5, 1'b0, 1'b0, w);
    send_beat(mkbeat(LM, 903), 16'hFFFF, 4'h6, 1'b1, 1'b0, w);
    drain("midrst_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
